// File: rtl/os_inst_sequencer_if.sv
// Bundle between the OS instruction sequencer and its environment: the start
// request and core status flags going in, the 34-bit core instruction word and
// the sequencer status coming out.
interface os_inst_sequencer_if;
    logic        start;
    logic        ififo_full;
    logic        l0_full;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic [2:0]  out_idx;
    logic        err;

    // Sequencer side: drives the instruction word and status.
    modport master (
        input  start, ififo_full, l0_full, ofifo_valid,
        output inst, busy, done, out_valid, out_idx, err
    );

    // Controller / core side: requests a tile and supplies FIFO status.
    modport slave (
        output start, ififo_full, l0_full, ofifo_valid,
        input  inst, busy, done, out_valid, out_idx, err
    );
endinterface

// File: rtl/os_inst_sequencer.sv
// Output-stationary instruction sequencer. On start it streams the weight
// block from high XMEM into the IFIFO, the activation block from low XMEM into
// L0, runs execute/drain, then pulls col output rows from the OFIFO.
// Every output is a register; the FSM loads the word for the state/count it
// is entering, so the displayed word always matches state_r/cnt_r.
module os_inst_sequencer #(
    parameter int          row     = 8,
    parameter int          col     = 8,
    parameter int          len_kij = 9,
    parameter int          ic_dim  = 3,
    parameter logic [10:0] W_BASE  = 11'h400,
    parameter logic [10:0] X_BASE  = 11'h000,
    parameter int          GAP     = 10
) (
    input  logic                clk,
    input  logic                reset,
    os_inst_sequencer_if.master bus
);

    localparam int N        = len_kij * ic_dim;
    localparam int EXEC_LEN = N + row + col;
    localparam int CNT_MAX  = (EXEC_LEN > GAP) ? EXEC_LEN : GAP;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int RCNT_W   = $clog2(col + 1);

    localparam logic [CNT_W-1:0]  N_C        = CNT_W'(N);
    localparam logic [CNT_W-1:0]  GAP_LAST_C = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0]  EXEC_END_C = CNT_W'(EXEC_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE_C  = CNT_W'(1);
    localparam logic [RCNT_W-1:0] RD_LAST_C  = RCNT_W'(col - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE_C = RCNT_W'(1);

    // Low control field [6:0]: ofifo_rd ififo_wr ififo_rd l0_rd l0_wr execute load
    localparam logic [6:0] CTL_NONE   = 7'b000_0000;
    localparam logic [6:0] CTL_IF_WR  = 7'b010_0000;
    localparam logic [6:0] CTL_L0_WR  = 7'b000_0100;
    localparam logic [6:0] CTL_RD     = 7'b001_1000;
    localparam logic [6:0] CTL_EXEC   = 7'b001_1010;
    localparam logic [6:0] CTL_OF_RD  = 7'b100_0000;

    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_W_RD     = 4'd1,
        ST_W_GAP    = 4'd2,
        ST_X_RD     = 4'd3,
        ST_X_GAP    = 4'd4,
        ST_EX_PRE   = 4'd5,
        ST_EXEC     = 4'd6,
        ST_OUT_WAIT = 4'd7,
        ST_OUT_RD   = 4'd8
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [RCNT_W-1:0]   rcnt_r;
    logic [33:0]         inst_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                out_valid_r;
    logic [2:0]          out_idx_r;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [RCNT_W-1:0]   rcnt_inc_s;
    logic                overflow_s;

    // Assemble a full word; PMEM is never touched and XMEM is read-only.
    function automatic logic [33:0] make_inst(input logic        cen_x,
                                              input logic [10:0] a_x,
                                              input logic [6:0]  ctl);
        make_inst = {1'b0, 1'b1, 1'b1, 11'd0, cen_x, 1'b1, a_x, ctl};
    endfunction

    // Word for transfer step idx: SRAM read for idx<N, FIFO write for idx>=1,
    // so the write trails the read by the one-cycle SRAM latency.
    function automatic logic [33:0] xfer_inst(input logic [10:0]      base,
                                              input logic [CNT_W-1:0] idx,
                                              input logic [6:0]       wr_ctl);
        logic [6:0] ctl;
        if (idx != {CNT_W{1'b0}}) begin
            ctl = wr_ctl;
        end else begin
            ctl = CTL_NONE;
        end
        if (idx < N_C) begin
            xfer_inst = make_inst(1'b0, base + 11'(idx), ctl);
        end else begin
            xfer_inst = make_inst(1'b1, 11'd0, ctl);
        end
    endfunction

    // Incremented counters shared by several states.
    always_comb begin
        cnt_inc_s  = cnt_r + CNT_ONE_C;
        rcnt_inc_s = rcnt_r + RCNT_ONE_C;
        overflow_s = (inst_r[5] & bus.ififo_full) | (inst_r[2] & bus.l0_full);
    end

    // Main sequencing FSM with registered instruction word, busy and done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            rcnt_r  <= {RCNT_W{1'b0}};
            inst_r  <= IDLE_INST;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r <= ST_W_RD;
                        cnt_r   <= {CNT_W{1'b0}};
                        rcnt_r  <= {RCNT_W{1'b0}};
                        inst_r  <= xfer_inst(W_BASE, {CNT_W{1'b0}}, CTL_IF_WR);
                        busy_r  <= 1'b1;
                    end else begin
                        inst_r <= IDLE_INST;
                        busy_r <= 1'b0;
                    end
                end
                ST_W_RD: begin
                    if (cnt_r == N_C) begin
                        state_r <= ST_W_GAP;
                        cnt_r   <= {CNT_W{1'b0}};
                        inst_r  <= IDLE_INST;
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        inst_r <= xfer_inst(W_BASE, cnt_inc_s, CTL_IF_WR);
                    end
                end
                ST_W_GAP: begin
                    if (cnt_r == GAP_LAST_C) begin
                        state_r <= ST_X_RD;
                        cnt_r   <= {CNT_W{1'b0}};
                        inst_r  <= xfer_inst(X_BASE, {CNT_W{1'b0}}, CTL_L0_WR);
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        inst_r <= IDLE_INST;
                    end
                end
                ST_X_RD: begin
                    if (cnt_r == N_C) begin
                        state_r <= ST_X_GAP;
                        cnt_r   <= {CNT_W{1'b0}};
                        inst_r  <= IDLE_INST;
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        inst_r <= xfer_inst(X_BASE, cnt_inc_s, CTL_L0_WR);
                    end
                end
                ST_X_GAP: begin
                    if (cnt_r == GAP_LAST_C) begin
                        state_r <= ST_EX_PRE;
                        cnt_r   <= {CNT_W{1'b0}};
                        inst_r  <= make_inst(1'b1, 11'd0, CTL_RD);
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        inst_r <= IDLE_INST;
                    end
                end
                ST_EX_PRE: begin
                    state_r <= ST_EXEC;
                    cnt_r   <= {CNT_W{1'b0}};
                    inst_r  <= make_inst(1'b1, 11'd0, CTL_EXEC);
                end
                ST_EXEC: begin
                    // cnt 0..EXEC_LEN-1 execute, cnt EXEC_LEN is the quiet cycle
                    if (cnt_r == EXEC_END_C) begin
                        state_r <= ST_OUT_WAIT;
                        cnt_r   <= {CNT_W{1'b0}};
                        inst_r  <= IDLE_INST;
                    end else if (cnt_inc_s == EXEC_END_C) begin
                        cnt_r  <= cnt_inc_s;
                        inst_r <= IDLE_INST;
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        inst_r <= make_inst(1'b1, 11'd0, CTL_EXEC);
                    end
                end
                ST_OUT_WAIT: begin
                    // rcnt_r already holds the index of the next row to read
                    if (bus.ofifo_valid) begin
                        state_r <= ST_OUT_RD;
                        inst_r  <= make_inst(1'b1, 11'd0, CTL_OF_RD);
                        done_r  <= (rcnt_r == RD_LAST_C);
                    end else begin
                        inst_r <= IDLE_INST;
                    end
                end
                ST_OUT_RD: begin
                    // a read of row rcnt_r is on the bus this cycle
                    if (rcnt_r == RD_LAST_C) begin
                        state_r <= ST_IDLE;
                        rcnt_r  <= {RCNT_W{1'b0}};
                        inst_r  <= IDLE_INST;
                        busy_r  <= 1'b0;
                    end else if (bus.ofifo_valid) begin
                        rcnt_r <= rcnt_inc_s;
                        inst_r <= make_inst(1'b1, 11'd0, CTL_OF_RD);
                        done_r <= (rcnt_inc_s == RD_LAST_C);
                    end else begin
                        state_r <= ST_OUT_WAIT;
                        rcnt_r  <= rcnt_inc_s;
                        inst_r  <= IDLE_INST;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    rcnt_r  <= {RCNT_W{1'b0}};
                    inst_r  <= IDLE_INST;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag: write issued into a full FIFO; cleared by an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && bus.start) begin
            err_r <= 1'b0;
        end else if (overflow_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Row qualifier: the OFIFO row appears one cycle after its ofifo_rd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_idx_r   <= 3'd0;
        end else begin
            out_valid_r <= inst_r[6];
            out_idx_r   <= 3'(rcnt_r);
        end
    end

    assign bus.inst      = inst_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_idx   = out_idx_r;

endmodule
